cart_bus_if: RTL and testbench
==============================

# cart_bus_if

Parametrised Atari 7800 cartridge bus interface for the 27 MHz system clock domain. Synchronises the raw cartridge-edge signals and decodes the address map. Runs a per-access bus state machine that drives ROM data and the buffer controls. Adds SuperGame-style bank switching, a configurable number of 16-byte peripheral write windows, a menu control register and a PHI2 activity detector. Sits between the cartridge-edge pins and the ROM store, POKEY instances and debug logic.

## Interface
- SYNC_STAGES, 2: flop stages on a, phi2, rw, halt, d_in (min 2).
- BANK_W, 3: bank register width; ROM_ADDR_W = BANK_W+14.
- SETTLE_CYCLES, 3: consecutive stable-address cycles required before driving (1..15).
- PERIPH_BASE, 16'h0450: base of peripheral windows, 16-byte aligned.
- PERIPH_CNT, 2: number of contiguous 16-byte peripheral windows (1..4).
- MENU_ADDR, 16'h2200: menu control register address.
- ACTIVE_TIMEOUT, 23'h100000: clk cycles without a PHI2 edge before atari_active drops.

Ports:
- clk  in  1  27 MHz system clock.
- reset_n  in  1  synchronous, active-low reset.
- a  in  16  cartridge address bus, asynchronous.
- d_in  in  8  cartridge data bus input, asynchronous.
- phi2, rw, halt  in  1 each  Atari bus controls, asynchronous.
- rom_addr  out  ROM_ADDR_W  registered ROM byte address.
- rom_data  in  8  ROM read data, valid one clk after rom_addr.
- d_out  out  8  data to drive onto the bus.
- d_oe  out  1  FPGA tristate enable for d.
- buf_dir  out  1  level-shifter direction: 1 = cart to Atari.
- buf_oe  out  1  level-shifter enable, active low.
- per_sel  out  PERIPH_CNT  one-hot window select, valid with per_we.
- per_addr  out  4  peripheral register index.
- per_wdata  out  8  peripheral write data.
- per_we  out  1  one-clk write pulse.
- bank  out  BANK_W  current bank register.
- menu_reg  out  8  last value written to MENU_ADDR.
- menu_strobe  out  1  one-clk pulse on a menu write.
- atari_active  out  1  PHI2 toggling within ACTIVE_TIMEOUT.

## Operation
- Inputs pass through SYNC_STAGES flops. All logic uses synchronised copies (a_s, phi2_s, rw_s, halt_s, d_s). phi2 edges are detected from the last two synchronised samples.
- Decode on a_s:
  - rom: a_s[15:14] != 0.
  - periph k: a_s[15:4] == PERIPH_BASE[15:4]+k.
  - menu: a_s == MENU_ADDR.
  - bankwr: a_s[15:14] == 2'b10.
- ROM map, with rom_addr = {sel, a_s[13:0]}:
  - $4000-$7FFF: sel = all-ones minus 1.
  - $8000-$BFFF: sel = bank.
  - $C000-$FFFF: sel = all-ones.
- Bus window: cpu = phi2_s & halt_s; dma = !halt_s.
- FSM states: IDLE, SETTLE, DRIVE, WRITE.
  - IDLE -> SETTLE: when (cpu|dma) and rw_s. Load settle counter, register rom_addr.
  - IDLE -> WRITE: when cpu and !rw_s.
  - SETTLE: any a_s change reloads the counter. When the counter expires: DRIVE if rom, otherwise IDLE.
  - DRIVE: d_oe=1, buf_oe=0, buf_dir=1, d_out=rom_data. Exit to IDLE on phi2 falling edge in cpu mode, any a_s change, rw_s low, or leaving the rom region. In dma mode, a changed address returns to SETTLE.
  - WRITE: d_s is captured every clk while phi2_s is high. Enabling the buffer (buf_oe=0, buf_dir=0) requires a decoded write target (periph, menu or bankwr). On the phi2 falling edge, commit the sample taken on the previous clk, then go to IDLE. Exactly one commit per PHI2 cycle.
- Commit actions:
  - periph: per_we pulse, with per_sel, per_addr = a_s[3:0] and per_wdata.
  - menu: menu_reg <= data, menu_strobe pulse.
  - bankwr: bank <= data[BANK_W-1:0]; upper bits are ignored.
- Writes while halt_s is low are ignored. Writes to $4000-$7FFF and $C000-$FFFF are ignored.
- Activity detector: any phi2 edge sets atari_active and reloads the timer. When the timer reaches 0, atari_active clears.

## Timing
- Reset values: d_oe=0, buf_oe=1, buf_dir=1, d_out=0, per_we=0, per_sel=0, per_addr=0, per_wdata=0, bank=0, menu_reg=0, menu_strobe=0, atari_active=0, rom_addr=0, FSM=IDLE, timer=0.
- Reset asserted mid-access: all outputs take their reset values on the next clk edge, including a DRIVE or WRITE in progress. Nothing is committed.
- Pin to synchronised latency: SYNC_STAGES clk.
- Read latency: drive begins SETTLE_CYCLES+1 clk after a stable a_s is first seen in IDLE; rom_data is valid before d_oe rises.
- Release latency: d_oe and buf_oe release on the same clk, one clk after the exit condition is seen.
- per_we and menu_strobe are single clk wide. They fire 1 clk after the phi2_s falling edge is detected.
- Bank write followed by a read of $8000-$BFFF in the next PHI2 cycle returns data from the new bank.

## Test plan
- Reset, then CPU read of $C123: rom_addr = {111, 0x0123} with BANK_W=3; d_out = ROM byte; d_oe=1 and buf_oe=0 after 1+SETTLE_CYCLES clk; both release 1 clk after the phi2 fall.
- Write 0x05 to $8000, then read $8010: bank=5, rom_addr = 0x14010, d_out = ROM[0x14010]. Write 0xFD: bank=5 (data[2:0]=101).
- CPU write 0xA7 to $0462 with PERIPH_CNT=2: per_sel=2'b10, per_addr=2, per_wdata=0xA7; exactly one per_we pulse. Write to $0472: no per_we.
- halt low, address stepping $4000, $4001 every 8 clk: DRIVE re-enters SETTLE on each change and drives ROM[0x18000], then ROM[0x18001]. Write during halt low: ignored.
- Write 0x3C to $2200: menu_reg=0x3C, one menu_strobe pulse. Address jitter inside SETTLE delays the drive until SETTLE_CYCLES stable cycles have elapsed.
- PHI2 stops: atari_active falls after ACTIVE_TIMEOUT clk. reset_n low during DRIVE: buf_oe=1 and d_oe=0 on the next edge.

Source files
------------

// File: rtl/cart_bus_if.sv
// cart_bus_if: Atari 7800 cartridge-edge interface for the 27 MHz domain.
// Synchronises the raw bus, decodes the address map, runs the per-access bus
// FSM (read drive / write capture), and holds the bank, menu and activity state.
//
// Handshake note: there is no valid/ready pair here. per_we and menu_strobe
// are single-clk pulses; per_sel/per_addr/per_wdata and menu_reg are valid
// on the same clk as their pulse and hold until the next commit.
module cart_bus_if #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          BANK_W         = 3,
  parameter int          SETTLE_CYCLES  = 3,
  parameter logic [15:0] PERIPH_BASE    = 16'h0450,
  parameter int          PERIPH_CNT     = 2,
  parameter logic [15:0] MENU_ADDR      = 16'h2200,
  parameter logic [22:0] ACTIVE_TIMEOUT = 23'h100000,
  localparam int         ROM_ADDR_W     = BANK_W + 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           a,
  input  logic [7:0]            d_in,
  input  logic                  phi2,
  input  logic                  rw,
  input  logic                  halt,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [7:0]            d_out,
  output logic                  d_oe,
  output logic                  buf_dir,
  output logic                  buf_oe,
  output logic [PERIPH_CNT-1:0] per_sel,
  output logic [3:0]            per_addr,
  output logic [7:0]            per_wdata,
  output logic                  per_we,
  output logic [BANK_W-1:0]     bank,
  output logic [7:0]            menu_reg,
  output logic                  menu_strobe,
  output logic                  atari_active
);

  typedef enum logic [1:0] {IDLE, SETTLE, DRIVE, WRITE} state_t;

  localparam logic [BANK_W-1:0] SEL_TOP     = {BANK_W{1'b1}};
  localparam logic [BANK_W-1:0] SEL_LOW     = SEL_TOP - BANK_W'(1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t state, state_n;

  logic [26:0] sync_q [SYNC_STAGES];
  logic [15:0] a_s, a_prev;
  logic [7:0]  d_s, wdata;
  logic        phi2_s, rw_s, halt_s, phi2_d;
  logic [3:0]  cnt;
  logic [22:0] timer;

  logic cpu, dma, phi2_fall, phi2_edge, a_chg, commit;
  logic rom_hit, bankwr_hit, menu_hit, periph_hit, write_tgt;
  logic [PERIPH_CNT-1:0] per_hit;
  logic [BANK_W-1:0]     sel;

  // Synchroniser chain: all asynchronous pins travel together
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {a, d_in, phi2, rw, halt};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {a_s, d_s, phi2_s, rw_s, halt_s} = sync_q[SYNC_STAGES-1];

  // One-clk history of phi2_s and a_s for edge and change detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phi2_d <= 1'b0;
      a_prev <= '0;
    end else begin
      phi2_d <= phi2_s;
      a_prev <= a_s;
    end
  end

  assign cpu       = phi2_s & halt_s;
  assign dma       = ~halt_s;
  assign phi2_fall = phi2_d & ~phi2_s;
  assign phi2_edge = phi2_d ^ phi2_s;
  assign a_chg     = (a_s != a_prev);

  // Address decode and ROM bank selection
  always_comb begin
    for (int k = 0; k < PERIPH_CNT; k++) begin
      per_hit[k] = (a_s[15:4] == (PERIPH_BASE[15:4] + 12'(k)));
    end
    case (a_s[15:14])
      2'b01:   sel = SEL_LOW;
      2'b10:   sel = bank;
      2'b11:   sel = SEL_TOP;
      default: sel = '0;
    endcase
  end

  assign rom_hit    = |a_s[15:14];
  assign bankwr_hit = (a_s[15:14] == 2'b10);
  assign menu_hit   = (a_s == MENU_ADDR);
  assign periph_hit = |per_hit;
  assign write_tgt  = periph_hit | menu_hit | bankwr_hit;
  assign commit     = (state == WRITE) && halt_s && phi2_fall;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if ((cpu | dma) && rw_s)  state_n = SETTLE;
        else if (cpu && !rw_s)    state_n = WRITE;
      end
      SETTLE: begin
        if (!(cpu | dma) || !rw_s)        state_n = IDLE;
        else if (!a_chg && cnt == 4'd0)   state_n = rom_hit ? DRIVE : IDLE;
      end
      DRIVE: begin
        if (!rw_s || !rom_hit || !(cpu | dma) || (halt_s && phi2_fall)) state_n = IDLE;
        else if (a_chg) state_n = dma ? SETTLE : IDLE;
      end
      WRITE: begin
        if (!halt_s || phi2_fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: bus drive and level-shifter control
  always_comb begin
    d_oe    = (state == DRIVE);
    d_out   = (state == DRIVE) ? rom_data : 8'h00;
    buf_oe  = !((state == DRIVE) || ((state == WRITE) && write_tgt));
    buf_dir = !((state == WRITE) && write_tgt);
  end

  // Settle counter and ROM address tracking while the address settles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= '0;
      rom_addr <= '0;
    end else begin
      if (state_n == SETTLE && (state != SETTLE || a_chg)) cnt <= SETTLE_LOAD;
      else if (state == SETTLE && cnt != 4'd0)             cnt <= cnt - 4'd1;
      if (state_n == SETTLE || state == SETTLE) rom_addr <= {sel, a_s[13:0]};
    end
  end

  // Write data capture and commit to peripheral, menu and bank registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdata       <= '0;
      per_we      <= 1'b0;
      per_sel     <= '0;
      per_addr    <= '0;
      per_wdata   <= '0;
      menu_strobe <= 1'b0;
      menu_reg    <= '0;
      bank        <= '0;
    end else begin
      if (state == WRITE && phi2_s) wdata <= d_s;
      per_we      <= commit && periph_hit;
      menu_strobe <= commit && menu_hit;
      if (commit && periph_hit) begin
        per_sel   <= per_hit;
        per_addr  <= a_s[3:0];
        per_wdata <= wdata;
      end
      if (commit && menu_hit)   menu_reg <= wdata;
      if (commit && bankwr_hit) bank     <= wdata[BANK_W-1:0];
    end
  end

  // PHI2 activity detector: any edge rearms, expiry clears atari_active
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer        <= '0;
      atari_active <= 1'b0;
    end else if (phi2_edge) begin
      timer        <= ACTIVE_TIMEOUT;
      atari_active <= 1'b1;
    end else if (timer != 23'd0) begin
      timer <= timer - 23'd1;
      if (timer == 23'd1) atari_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_bus_if.sv
// tb_cart_bus_if: scoreboard bench for cart_bus_if with directed and random
// cartridge bus cycles. Expected bus reads and register commits are derived
// from the memory map with a small behavioural model (BANK_W = 3).
module tb_cart_bus_if;
  localparam int ACT = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        phi2, rw, halt;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  d_out;
  logic        d_oe, buf_dir, buf_oe;
  logic [1:0]  per_sel;
  logic [3:0]  per_addr;
  logic [7:0]  per_wdata;
  logic        per_we;
  logic [2:0]  bank;
  logic [7:0]  menu_reg;
  logic        menu_strobe, atari_active;

  cart_bus_if #(.ACTIVE_TIMEOUT(23'(ACT))) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .d_in(d_in), .phi2(phi2), .rw(rw),
    .halt(halt), .rom_addr(rom_addr), .rom_data(rom_data), .d_out(d_out),
    .d_oe(d_oe), .buf_dir(buf_dir), .buf_oe(buf_oe), .per_sel(per_sel),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_we(per_we), .bank(bank),
    .menu_reg(menu_reg), .menu_strobe(menu_strobe), .atari_active(atari_active)
  );

  // ---------------- clock / ROM store ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [16:0] ad);
    return 8'(ad[7:0] * 8'd29) ^ ad[15:8] ^ {ad[16], ad[14], 6'd0} ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_pass = 0;
  int per_seen = 0;
  int per_exp = 0;
  logic [24:0] rd_q[$];
  logic [13:0] per_q[$];
  logic [7:0]  menu_q[$];
  logic [2:0]  bank_m = 3'd0;
  logic        d_oe_q = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference memory map: which ROM byte a CPU address selects
  function automatic logic [16:0] map_addr(input logic [15:0] ad, input logic [2:0] bk);
    case (ad[15:14])
      2'd1:    return {3'b110, ad[13:0]};
      2'd2:    return {bk, ad[13:0]};
      default: return {3'b111, ad[13:0]};
    endcase
  endfunction

  // Reference write effect; reports whether the address is a write target
  task automatic model_write(input logic [15:0] ad, input logic [7:0] dt, output bit tgt);
    int k;
    tgt = 1'b1;
    if (ad == 16'h2200) menu_q.push_back(dt);
    else if (ad >= 16'h0450 && ad < 16'h0470) begin
      k = (int'(ad) - 'h450) / 16;
      per_q.push_back({2'(1 << k), ad[3:0], dt});
      per_exp++;
    end
    else if (ad >= 16'h8000 && ad < 16'hC000) bank_m = dt[2:0];
    else tgt = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [24:0] er;
    logic [13:0] ep;
    logic [7:0]  em;
    if (reset_n) begin
      if (d_oe && !d_oe_q) begin
        if (rd_q.size() == 0) chk(1'b0, "spurious_drive", {15'd0, rom_addr}, 0);
        else begin
          er = rd_q.pop_front();
          chk(rom_addr == er[24:8], "rd_rom_addr", {15'd0, rom_addr}, {15'd0, er[24:8]});
          chk(d_out == er[7:0], "rd_d_out", {24'd0, d_out}, {24'd0, er[7:0]});
          chk(!buf_oe && buf_dir, "rd_buf", {30'd0, buf_oe, buf_dir}, 32'h1);
        end
      end
      if (per_we) begin
        per_seen++;
        if (per_q.size() == 0) chk(1'b0, "spurious_per_we", {16'd0, per_sel, per_addr, per_wdata}, 0);
        else begin
          ep = per_q.pop_front();
          chk({per_sel, per_addr, per_wdata} == ep, "per_write",
              {18'd0, per_sel, per_addr, per_wdata}, {18'd0, ep});
        end
      end
      if (menu_strobe) begin
        if (menu_q.size() == 0) chk(1'b0, "spurious_menu", {24'd0, menu_reg}, 0);
        else begin
          em = menu_q.pop_front();
          chk(menu_reg == em, "menu_reg", {24'd0, menu_reg}, {24'd0, em});
        end
      end
    end
    d_oe_q = d_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_oe(input logic v, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (d_oe !== v && n < 40);
  endtask

  task automatic cpu_read(input logic [15:0] ad);
    logic [16:0] ra;
    ra = map_addr(ad, bank_m);
    if (ad[15:14] != 2'b00) rd_q.push_back({ra, rom_fn(ra)});
    a = ad; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    step(12);
    phi2 = 1'b0;
    step(6);
  endtask

  task automatic cpu_write(input logic [15:0] ad, input logic [7:0] dt);
    bit tgt;
    model_write(ad, dt, tgt);
    a = ad; d_in = dt; rw = 1'b0; halt = 1'b1; phi2 = 1'b1;
    step(6);
    chk(buf_oe == !tgt, "wr_buf_oe", {31'd0, buf_oe}, {31'd0, !tgt});
    chk(buf_dir == !tgt, "wr_buf_dir", {31'd0, buf_dir}, {31'd0, !tgt});
    step(2);
    phi2 = 1'b0;
    step(4);
    rw = 1'b1; d_in = 8'($urandom);
    step(2);
    chk(bank == bank_m, "bank_reg", {29'd0, bank}, {29'd0, bank_m});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int t;
    logic [15:0] ad;
    logic [16:0] ra;
    reset_n = 1'b0; a = 16'h0000; d_in = 8'h00; phi2 = 1'b0; rw = 1'b1; halt = 1'b1;
    step(4);
    chk(d_oe == 1'b0 && buf_oe == 1'b1 && buf_dir == 1'b1, "reset_buf",
        {29'd0, d_oe, buf_oe, buf_dir}, 32'h3);
    chk(d_out == 8'h00 && rom_addr == 17'd0, "reset_data", {7'd0, rom_addr, d_out}, 0);
    chk(per_we == 1'b0 && per_sel == 2'd0 && per_addr == 4'd0 && per_wdata == 8'd0,
        "reset_per", {17'd0, per_we, per_sel, per_addr, per_wdata}, 0);
    chk(bank == 3'd0 && menu_reg == 8'd0 && menu_strobe == 1'b0 && atari_active == 1'b0,
        "reset_regs", {19'd0, bank, menu_reg, menu_strobe, atari_active}, 0);
    reset_n = 1'b1;
    step(4);

    // CPU read of $C123 with drive and release latency
    ra = map_addr(16'hC123, bank_m);
    rd_q.push_back({ra, rom_fn(ra)});
    a = 16'hC123; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    wait_oe(1'b1, n);
    chk(n == 6, "read_latency", n, 6);
    step(3);
    chk(rom_addr == 17'h1C123, "c123_rom_addr", {15'd0, rom_addr}, 32'h1C123);
    chk(d_out == rom_fn(17'h1C123), "c123_d_out", {24'd0, d_out}, {24'd0, rom_fn(17'h1C123)});
    phi2 = 1'b0;
    wait_oe(1'b0, n);
    chk(n == 3, "release_latency", n, 3);
    chk(buf_oe == 1'b1, "release_buf_oe", {31'd0, buf_oe}, 1);
    chk(atari_active == 1'b1, "active_on", {31'd0, atari_active}, 1);
    step(4);

    // Bank switching
    cpu_write(16'h8000, 8'h05);
    cpu_read(16'h8010);
    cpu_write(16'h8000, 8'hFD);

    // Peripheral windows, in range and one past the last window
    cpu_write(16'h0462, 8'hA7);
    cpu_write(16'h0472, 8'h11);

    // DMA stepping with halt low
    a = 16'h4000; rw = 1'b1; halt = 1'b0; phi2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 16'h4000 + 16'(i);
      ra = map_addr(a, bank_m);
      rd_q.push_back({ra, rom_fn(ra)});
      step(8);
    end
    halt = 1'b1;
    step(6);

    // Write attempt while halt is low
    a = 16'h8000; d_in = 8'h07; rw = 1'b0; halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phi2 = 1'b1; step(4);
      phi2 = 1'b0; step(4);
    end
    rw = 1'b1; halt = 1'b1;
    step(4);
    chk(bank == bank_m, "halt_write_ignored", {29'd0, bank}, {29'd0, bank_m});

    // Menu register
    cpu_write(16'h2200, 8'h3C);

    // Address jitter while settling
    ra = map_addr(16'hC777, bank_m);
    rd_q.push_back({ra, rom_fn(ra)});
    a = 16'h4005; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    step(2); a = 16'h4006;
    step(2); a = 16'hC777;
    wait_oe(1'b1, n);
    chk(n == 6, "jitter_latency", n, 6);
    step(3);
    phi2 = 1'b0;
    step(6);

    // Randomised bus traffic
    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 9);
      ad = 16'($urandom_range(0, 65535));
      case (t)
        0, 1, 2, 3: cpu_read(ad);
        4: cpu_write({2'b10, ad[13:0]}, 8'($urandom));
        5: cpu_write(16'h0450 + 16'($urandom_range(0, 47)), 8'($urandom));
        6: cpu_write(16'h2200, 8'($urandom));
        7: cpu_write(ad | 16'h4000, 8'($urandom));
        8: cpu_write(ad, 8'($urandom));
        default: step($urandom_range(1, 6));
      endcase
    end

    // Reset in the middle of a drive
    ra = map_addr(16'hC010, bank_m);
    rd_q.push_back({ra, rom_fn(ra)});
    a = 16'hC010; rw = 1'b1; halt = 1'b1; phi2 = 1'b1;
    wait_oe(1'b1, n);
    chk(n == 6, "pre_reset_drive", n, 6);
    step(2);
    reset_n = 1'b0;
    step(1);
    chk(d_oe == 1'b0 && buf_oe == 1'b1, "reset_mid_drive", {30'd0, d_oe, buf_oe}, 1);
    a = 16'h0000; phi2 = 1'b0;
    step(4);
    reset_n = 1'b1;
    bank_m = 3'd0;
    step(2);
    chk(bank == 3'd0 && menu_reg == 8'd0, "regs_after_reset", {21'd0, bank, menu_reg}, 0);

    // Activity detector timeout
    for (int i = 0; i < 3; i++) begin
      phi2 = 1'b1; step(4);
      phi2 = 1'b0; step(4);
    end
    chk(atari_active == 1'b1, "active_toggling", {31'd0, atari_active}, 1);
    step(ACT - 10 - 4);
    chk(atari_active == 1'b1, "active_before_timeout", {31'd0, atari_active}, 1);
    step(20);
    chk(atari_active == 1'b0, "active_after_timeout", {31'd0, atari_active}, 0);

    // Drain checks
    chk(rd_q.size() == 0, "reads_pending", rd_q.size(), 0);
    chk(per_q.size() == 0, "per_pending", per_q.size(), 0);
    chk(menu_q.size() == 0, "menu_pending", menu_q.size(), 0);
    chk(per_seen == per_exp, "per_we_count", per_seen, per_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
